cpu_fetch: RTL and testbench
============================

CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h00000000, meaning the first fetch address after reset.
REQ-002 SHALL have port CLK  input  1  system clock; the block has one clock.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port mem_req  output  1  instruction memory read request.
REQ-005 SHALL have port mem_addr  output  32  word-aligned fetch address.
REQ-006 SHALL have port mem_ack  input  1  read complete; mem_rdata valid this cycle.
REQ-007 SHALL have port mem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port branch_valid  input  1  redirect request from execute.
REQ-009 SHALL have port branch_target  input  32  redirect address.
REQ-010 SHALL have port instruction  output  32  instruction to cpu_decode.
REQ-011 SHALL have port instr_pc  output  32  address of the instruction.
REQ-012 SHALL have port instr_valid  output  1  instruction/instr_pc valid.
REQ-013 SHALL have port instr_ready  input  1  decode accepts this cycle.

Function
REQ-014 SHALL hold a 32-bit PC; PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-015 SHALL have states IDLE (no request), REQ (mem_req high, awaiting ack) and FLUSH (awaiting ack of a request to be discarded).
REQ-016 SHALL allow at most one outstanding memory request.
REQ-017 In REQ, mem_req and mem_addr SHALL stay stable until the cycle mem_ack is sampled high.
REQ-018 SHALL buffer fetched words with their PC in a 2-entry FIFO; instruction/instr_pc/instr_valid SHALL be driven from the FIFO head.
REQ-019 SHALL issue a new request only when FIFO occupancy plus outstanding requests is less than 2.
REQ-020 On mem_ack in REQ, SHALL push {mem_rdata, mem_addr}, set PC=PC+4 and, if room remains, keep mem_req high at the new address in the next cycle.
REQ-021 Data acked in cycle N SHALL appear with instr_valid=1 in cycle N+1 when the FIFO was empty; latency is 1 cycle.
REQ-022 A FIFO pop SHALL occur when instr_valid && instr_ready; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-023 While instr_valid=1 and instr_ready=0, instruction and instr_pc SHALL remain stable.
REQ-024 On branch_valid, SHALL flush the FIFO (instr_valid=0 next cycle) and set PC={branch_target[31:2],2'b00}.
REQ-025 A branch with a request outstanding and no ack in that cycle SHALL enter FLUSH; the pending ack's data SHALL be discarded; then the block SHALL go to REQ at the target.
REQ-026 A branch coinciding with mem_ack SHALL discard the acked data and go directly to REQ at the target next cycle.
REQ-027 A branch coinciding with a pop SHALL complete the pop at the interface and flush the remaining entries.
REQ-028 A branch while already in FLUSH SHALL update PC to the newer target and remain in FLUSH.
REQ-029 In FLUSH, mem_req and mem_addr SHALL hold their original values until ack.

Reset
REQ-030 While RST=1 at a CLK edge: PC=RESET_VECTOR, FIFO empty, state IDLE, mem_req=0, instr_valid=0, instruction=0, instr_pc=0, mem_addr=RESET_VECTOR.
REQ-031 In the first cycle after RST deasserts, SHALL assert mem_req with mem_addr=RESET_VECTOR.
REQ-032 RST mid-transaction SHALL abandon any outstanding request without waiting for ack; the memory side tolerates a dropped request.

Structure
REQ-033 SHALL place shared constants (instruction width 32, fetch state encodings, PC increment 4) in the shared CPU package used by cpu_decode.
REQ-034 SHALL implement the 2-entry buffer as sub-module cpu_fetch_fifo (64-bit entries, push/pop/full/empty).

Verification
REQ-035 Reset release, mem_ack every cycle, instr_ready=1 -> mem_addr 0,4,8,...; instr_valid from cycle 2, instr_pc tracks 0,4,8.
REQ-036 instr_ready=0 for 5 cycles, acks available -> exactly 2 words buffered, mem_req drops, instruction stable at word @0.
REQ-037 branch_valid with target 32'h00000102 while request @8 is outstanding, ack 3 cycles later -> word @8 dropped, next mem_addr=32'h00000100, instr_pc=32'h00000100.
REQ-038 branch_valid in the same cycle as mem_ack -> acked word never appears; mem_req at target next cycle.
REQ-039 RESET_VECTOR=32'hFFFFFFF8, continuous acks -> instr_pc sequence FFFFFFF8, FFFFFFFC, 00000000.
REQ-040 RST asserted during REQ -> next cycle mem_req=0, instr_valid=0; restart at RESET_VECTOR.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
//============================================================================
// Module   : cpu_pkg
// Desc     : Shared CPU constants and types used by cpu_fetch and cpu_decode
//            (instruction width, PC increment, fetch state encodings).
// Revision : 1.0 - initial release
//============================================================================
package cpu_pkg;

    localparam int          c_INSTR_WIDTH       = 32;
    localparam int          c_FETCH_ENTRY_WIDTH = 2 * c_INSTR_WIDTH;
    localparam logic [31:0] c_PC_INCREMENT      = 32'd4;
    localparam logic [31:0] c_WORD_ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [1:0]  c_FETCH_DEPTH       = 2'd2;

    // Fetch sequencer states, explicitly encoded
    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_FLUSH = 2'd2
    } fetch_state_t;

    // Force an address onto a 32-bit word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & c_WORD_ALIGN_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_fetch_fifo.sv
`default_nettype none
//============================================================================
// Module   : cpu_fetch_fifo
// Desc     : Two-entry FIFO holding {instruction, pc} pairs between the
//            fetch sequencer and decode. Flush empties it in one cycle.
// Revision : 1.0 - initial release
//============================================================================
module cpu_fetch_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign o_data    = r_mem[r_rd_ptr];
    // A full FIFO may still accept a word when its head leaves the same cycle
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    // Storage and pointer update; flush drops all entries but keeps storage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_fetch.sv
`default_nettype none
//============================================================================
// Module   : cpu_fetch
// Desc     : Instruction fetch unit. Single-outstanding memory requests,
//            2-entry prefetch buffer, branch redirect with discard of any
//            in-flight read.
// Revision : 1.0 - initial release
//============================================================================
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                     CLK,
    input  logic                     RST,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [c_INSTR_WIDTH-1:0] mem_rdata,
    input  logic                     branch_valid,
    input  logic [31:0]              branch_target,
    output logic [c_INSTR_WIDTH-1:0] instruction,
    output logic [31:0]              instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready
);

    fetch_state_t                   r_state;
    logic [31:0]                    r_pc;
    logic                           r_mem_req;
    logic [31:0]                    r_mem_addr;

    logic [c_FETCH_ENTRY_WIDTH-1:0] w_head;
    logic                           w_full;
    logic                           w_empty;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_ack;
    logic [1:0]                     w_occ;
    logic [1:0]                     w_occ_next;
    logic                           w_room;
    logic [31:0]                    w_target;
    logic [31:0]                    w_pc_inc;
    logic [31:0]                    w_pc_sel;

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr_valid = !w_empty;
    assign instruction = w_head[c_FETCH_ENTRY_WIDTH-1:c_INSTR_WIDTH];
    assign instr_pc    = w_head[c_INSTR_WIDTH-1:0];

    // An ack only counts against a request we actually have on the bus
    assign w_ack      = mem_ack && r_mem_req;
    assign w_pop      = instr_valid && instr_ready;
    // Acked data is only kept when it belongs to the current (un-redirected) stream
    assign w_push     = w_ack && (r_state == FETCH_REQ) && !branch_valid;
    assign w_occ      = {w_full, !w_full && !w_empty};
    assign w_occ_next = branch_valid ? 2'd0 : (w_occ + {1'b0, w_push} - {1'b0, w_pop});
    // Next request allowed only if the buffer will have a free slot for it
    assign w_room     = (w_occ_next < c_FETCH_DEPTH);
    assign w_target   = word_align(branch_target);
    assign w_pc_inc   = r_pc + c_PC_INCREMENT;
    assign w_pc_sel   = branch_valid ? w_target : r_pc;

    cpu_fetch_fifo #(
        .WIDTH (c_FETCH_ENTRY_WIDTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (branch_valid),
        .i_data  ({mem_rdata, r_mem_addr}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Fetch sequencer: owns PC and the registered memory request outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= FETCH_IDLE;
            r_pc       <= RESET_VECTOR;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_VECTOR;
        end else begin
            case (r_state)
                FETCH_IDLE: begin
                    r_pc <= w_pc_sel;
                    if (w_room) begin
                        r_state    <= FETCH_REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_pc_sel;
                    end
                end
                FETCH_REQ: begin
                    if (w_ack) begin
                        if (branch_valid) begin
                            // Acked word is stale; restart straight at the target
                            r_pc       <= w_target;
                            r_mem_addr <= w_target;
                        end else begin
                            r_pc       <= w_pc_inc;
                            r_mem_addr <= w_pc_inc;
                            if (!w_room) begin
                                r_state   <= FETCH_IDLE;
                                r_mem_req <= 1'b0;
                            end
                        end
                    end else if (branch_valid) begin
                        // Request must complete on the bus before redirecting
                        r_pc    <= w_target;
                        r_state <= FETCH_FLUSH;
                    end
                end
                FETCH_FLUSH: begin
                    r_pc <= w_pc_sel;
                    if (w_ack) begin
                        r_state    <= FETCH_REQ;
                        r_mem_addr <= w_pc_sel;
                    end
                end
                default: begin
                    r_state   <= FETCH_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_fetch.sv
`default_nettype none
//============================================================================
// Module   : tb_cpu_fetch
// Desc     : Directed self-checking bench for cpu_fetch with a scoreboard
//            of expected {instruction, pc} pairs.
// Revision : 1.0 - initial release
//============================================================================
module tb_cpu_fetch;

    localparam logic [31:0] c_RV = 32'hFFFF_FFF8;

    logic        CLK;
    logic        RST;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];

    cpu_fetch #(
        .RESET_VECTOR (c_RV)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .instruction   (instruction),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory contents: a fixed, address-dependent pattern
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return ~a ^ 32'h1234_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs #1 after the edge; a kept ack queues its expected entry
    task automatic cycle(input bit rdy, input bit ack, input bit br, input logic [31:0] tgt,
                         input bit drop, input logic [31:0] exp_pc);
        @(posedge CLK);
        #1;
        instr_ready   = rdy;
        branch_valid  = br;
        branch_target = tgt;
        mem_ack       = ack && mem_req;
        mem_rdata     = mem_req ? word_at(mem_addr) : 32'h0;
        if (mem_ack && !br && !drop && !RST)
            exp_q.push_back({word_at(exp_pc), exp_pc});
    endtask

    // Monitor: compare the presented head against the scoreboard every cycle
    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                exp_q.delete();
            end else begin
                if (instr_valid) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_instr: got pc %h instr %h expected none",
                                 instr_pc, instruction);
                    end else begin
                        if ({instruction, instr_pc} !== exp_q[0]) begin
                            n_fail++;
                            $display("FAIL head: got %h/%h expected %h/%h",
                                     instruction, instr_pc, exp_q[0][63:32], exp_q[0][31:0]);
                        end
                        if (instr_ready) void'(exp_q.pop_front());
                    end
                end
                if (branch_valid) exp_q.delete();
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0; branch_valid = 1'b0;
        branch_target = 32'h0; instr_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, c_RV);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instruction", instruction, 0);
        chk("rst_instr_pc", instr_pc, 0);
        RST = 1'b0;

        // Streaming from the reset vector through the 2^32 wrap
        cycle(1, 1, 0, 0, 0, 32'hFFFF_FFF8);
        chk("release_req", mem_req, 1);
        chk("release_addr", mem_addr, 32'hFFFF_FFF8);
        cycle(1, 1, 0, 0, 0, 32'hFFFF_FFFC);
        chk("lat1_valid", instr_valid, 1);
        chk("lat1_pc", instr_pc, 32'hFFFF_FFF8);
        chk("addr_fc", mem_addr, 32'hFFFF_FFFC);
        cycle(1, 1, 0, 0, 0, 32'h0000_0000);
        chk("addr_wrap", mem_addr, 32'h0000_0000);
        chk("pc_fc", instr_pc, 32'hFFFF_FFFC);
        cycle(1, 1, 0, 0, 0, 32'h0000_0004);
        chk("addr_4", mem_addr, 32'h4);
        chk("pc_wrap", instr_pc, 32'h0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("addr_8", mem_addr, 32'h8);
        chk("pc_4", instr_pc, 32'h4);

        // Branch while @8 outstanding, ack arrives three cycles later
        cycle(1, 0, 1, 32'h0000_0102, 0, 0);
        chk("req_hold_req", mem_req, 1);
        chk("req_hold_addr", mem_addr, 32'h8);
        chk("empty_before_br", instr_valid, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("flush_req", mem_req, 1);
        chk("flush_addr", mem_addr, 32'h8);
        cycle(1, 0, 0, 0, 0, 0);
        chk("flush_addr2", mem_addr, 32'h8);
        cycle(1, 1, 0, 0, 1, 0);
        chk("flush_addr3", mem_addr, 32'h8);
        cycle(1, 1, 0, 0, 0, 32'h100);
        chk("redirect_addr", mem_addr, 32'h100);
        chk("redirect_novalid", instr_valid, 0);

        // Branch coinciding with an ack and with a pop
        cycle(1, 1, 1, 32'h0000_0000, 0, 0);
        chk("target_pc", instr_pc, 32'h100);
        chk("target_valid", instr_valid, 1);

        // Stall: decode not ready, buffer fills to exactly two words
        cycle(0, 1, 0, 0, 0, 32'h0);
        chk("br_ack_req", mem_req, 1);
        chk("br_ack_addr", mem_addr, 32'h0);
        chk("br_ack_flushed", instr_valid, 0);
        cycle(0, 1, 0, 0, 0, 32'h4);
        chk("stall_pc", instr_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0, 0, 0);
            chk("stall_req_drop", mem_req, 0);
            chk("stall_instr", instruction, word_at(32'h0));
            chk("stall_pc_hold", instr_pc, 32'h0);
        end
        cycle(1, 1, 0, 0, 0, 0);
        chk("full_idle", mem_req, 0);
        cycle(1, 1, 0, 0, 0, 32'h8);
        chk("resume_req", mem_req, 1);
        chk("resume_addr", mem_addr, 32'h8);
        chk("resume_pc", instr_pc, 32'h4);
        cycle(1, 0, 0, 0, 0, 0);
        chk("pc_8", instr_pc, 32'h8);
        chk("addr_c", mem_addr, 32'hC);

        // Reset in the middle of an outstanding request
        RST = 1'b1;
        cycle(1, 0, 0, 0, 0, 0);
        chk("midrst_req", mem_req, 0);
        chk("midrst_valid", instr_valid, 0);
        chk("midrst_addr", mem_addr, c_RV);
        RST = 1'b0;
        cycle(1, 1, 0, 0, 0, 32'hFFFF_FFF8);
        chk("restart_req", mem_req, 1);
        chk("restart_addr", mem_addr, c_RV);
        cycle(1, 1, 0, 0, 0, 32'hFFFF_FFFC);
        chk("restart_pc", instr_pc, 32'hFFFF_FFF8);
        repeat (4) cycle(1, 0, 0, 0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
